// File: rtl/regfile_pkg.sv
// Shared defaults, address-width helper and busy-vector type for the multi-port register file.
package regfile_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int NREGS_DEF = 32;

    function automatic int calc_aw(input int nregs);
        return (nregs > 2) ? $clog2(nregs) : 1;
    endfunction

    localparam int AW_DEF = calc_aw(NREGS_DEF);

    typedef logic [NREGS_DEF-1:0] busy_vec_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Write-pending scoreboard: per-register busy bits with write clear, alloc set, flush
// and a registered population count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    localparam int AW   = calc_aw(NREGS)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [NREGS-1:0] clr_i,
    input  logic             alloc_i,
    input  logic [AW-1:0]    alloc_rd_i,
    input  logic             flush_i,
    output logic [NREGS-1:0] busy_o,
    output logic [AW:0]      busy_cnt_o
);

    logic [NREGS-1:0] busy_d, busy_q, set_s;
    logic [AW:0]      cnt_d, cnt_q;

    // Next busy vector: alloc beats a same-cycle write clear, flush beats everything.
    always_comb begin
        set_s = '0;
        if (alloc_i && (alloc_rd_i != '0)) begin
            set_s[alloc_rd_i] = 1'b1;
        end else begin
            set_s = '0;
        end
        if (flush_i) begin
            busy_d = '0;
        end else begin
            busy_d = (busy_q & ~clr_i) | set_s;
        end
        busy_d[0] = 1'b0;
        cnt_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_d = cnt_d + (AW+1)'(busy_d[i]);
        end
    end

    // Busy bits and their count are registered together so they never disagree.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-pending scoreboard and debug read port.
// Define REGFILE_BYPASS_EN to forward same-cycle write data (and mask busy) onto the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    localparam int AW   = calc_aw(NREGS)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [NRD*AW-1:0]   rs_i,
    output logic [NRD*XLEN-1:0] rdata_o,
    output logic [NRD-1:0]      busy_o,
    input  logic [NWR-1:0]      wen_i,
    input  logic [NWR*AW-1:0]   rd_i,
    input  logic [NWR*XLEN-1:0] wdata_i,
    input  logic                alloc_i,
    input  logic [AW-1:0]       alloc_rd_i,
    input  logic                flush_i,
    output logic [AW:0]         busy_cnt_o,
    input  logic [AW-1:0]       dbg_idx_i,
    output logic [XLEN-1:0]     dbg_data_o
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NWR-1:0]   wr_en_s;
    logic [AW-1:0]    wr_addr_s [NWR];
    logic [XLEN-1:0]  wr_data_s [NWR];
    logic [NREGS-1:0] clr_s;
    logic [NREGS-1:0] busy_s;
    logic [AW-1:0]    rd_addr_s [NRD];

    // Unpack write ports; writes to x0 are dropped here so nothing downstream sees them.
    always_comb begin
        for (int j = 0; j < NWR; j++) begin
            wr_addr_s[j] = rd_i[j*AW +: AW];
            wr_data_s[j] = wdata_i[j*XLEN +: XLEN];
            wr_en_s[j]   = wen_i[j] && (wr_addr_s[j] != '0);
        end
    end

    // Write priority mux: later ports overwrite earlier ones, so the highest port wins.
    always_comb begin
        clr_s = '0;
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            for (int j = 0; j < NWR; j++) begin
                regs_d[i] = (wr_en_s[j] && (wr_addr_s[j] == AW'(i))) ? wr_data_s[j] : regs_d[i];
                clr_s[i]  = clr_s[i] | (wr_en_s[j] && (wr_addr_s[j] == AW'(i)));
            end
        end
    end

    // Data array; entry 0 is never loaded by the mux above and stays zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clock      (clock),
        .reset_n    (reset_n),
        .clr_i      (clr_s),
        .alloc_i    (alloc_i),
        .alloc_rd_i (alloc_rd_i),
        .flush_i    (flush_i),
        .busy_o     (busy_s),
        .busy_cnt_o (busy_cnt_o)
    );

`ifdef REGFILE_BYPASS_EN
    logic [NRD-1:0] hit_s;

    // Read mux with forwarding; a same-cycle alloc keeps the registered busy bit visible.
    always_comb begin
        rdata_o = '0;
        busy_o  = '0;
        hit_s   = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_addr_s[k] = rs_i[k*AW +: AW];
            rdata_o[k*XLEN +: XLEN] = regs_q[rd_addr_s[k]];
            for (int j = 0; j < NWR; j++) begin
                if (reset_n && wr_en_s[j] && (wr_addr_s[j] == rd_addr_s[k])) begin
                    rdata_o[k*XLEN +: XLEN] = wr_data_s[j];
                    hit_s[k] = 1'b1;
                end else begin
                    hit_s[k] = hit_s[k];
                end
            end
            busy_o[k] = (hit_s[k] && !(alloc_i && (alloc_rd_i == rd_addr_s[k])))
                        ? 1'b0 : busy_s[rd_addr_s[k]];
        end
    end
`else
    // Read mux from stored values only.
    always_comb begin
        rdata_o = '0;
        busy_o  = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_addr_s[k] = rs_i[k*AW +: AW];
            rdata_o[k*XLEN +: XLEN] = regs_q[rd_addr_s[k]];
            busy_o[k] = busy_s[rd_addr_s[k]];
        end
    end
`endif

    assign dbg_data_o = regs_q[dbg_idx_i];

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: array/bit-list reference model checked every cycle,
// plus directed literal checks of the scenarios that matter.
module tb_regfile_mp;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int NWR   = 2;

    logic                clock;
    logic                reset_n;
    logic [NRD*AW-1:0]   rs_i;
    logic [NRD*XLEN-1:0] rdata_o;
    logic [NRD-1:0]      busy_o;
    logic [NWR-1:0]      wen_i;
    logic [NWR*AW-1:0]   rd_i;
    logic [NWR*XLEN-1:0] wdata_i;
    logic                alloc_i;
    logic [AW-1:0]       alloc_rd_i;
    logic                flush_i;
    logic [AW:0]         busy_cnt_o;
    logic [AW-1:0]       dbg_idx_i;
    logic [XLEN-1:0]     dbg_data_o;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rs_i       (rs_i),
        .rdata_o    (rdata_o),
        .busy_o     (busy_o),
        .wen_i      (wen_i),
        .rd_i       (rd_i),
        .wdata_i    (wdata_i),
        .alloc_i    (alloc_i),
        .alloc_rd_i (alloc_rd_i),
        .flush_i    (flush_i),
        .busy_cnt_o (busy_cnt_o),
        .dbg_idx_i  (dbg_idx_i),
        .dbg_data_o (dbg_data_o)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    logic [XLEN-1:0] m_mem [NREGS];
    bit              m_busy [NREGS];
    int              checks   = 0;
    int              failures = 0;
    bit              cmp_en   = 1'b0;

    task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Architectural effect of one clock edge.
    task automatic model_step();
        int a;
        for (int j = 0; j < NWR; j++) begin
            a = int'(rd_i[j*AW +: AW]);
            if (wen_i[j] && a != 0) begin
                m_mem[a]  = wdata_i[j*XLEN +: XLEN];
                m_busy[a] = 1'b0;
            end
        end
        if (alloc_i && alloc_rd_i != 5'd0) m_busy[int'(alloc_rd_i)] = 1'b1;
        if (flush_i) for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
    endtask

    function automatic bit fwd_hit(input logic [AW-1:0] a);
        bit h = 1'b0;
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NWR; j++)
            if (reset_n && wen_i[j] && a != 5'd0 && rd_i[j*AW +: AW] == a) h = 1'b1;
`endif
        return h;
    endfunction

    function automatic logic [XLEN-1:0] exp_rdata(input logic [AW-1:0] a);
        logic [XLEN-1:0] v = (a == 5'd0) ? 64'd0 : m_mem[int'(a)];
        if (fwd_hit(a))
            for (int j = 0; j < NWR; j++)
                if (wen_i[j] && rd_i[j*AW +: AW] == a) v = wdata_i[j*XLEN +: XLEN];
        return v;
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (fwd_hit(a) && !(alloc_i && alloc_rd_i == a)) return 1'b0;
        return m_busy[int'(a)];
    endfunction

    function automatic logic [AW:0] exp_cnt();
        logic [AW:0] c = '0;
        for (int i = 0; i < NREGS; i++) c = c + (m_busy[i] ? 6'd1 : 6'd0);
        return c;
    endfunction

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clock) begin
        if (cmp_en) begin
            for (int k = 0; k < NRD; k++) begin
                chk($sformatf("rdata%0d", k), rdata_o[k*XLEN +: XLEN], exp_rdata(rs_i[k*AW +: AW]));
                chk($sformatf("busy%0d", k), 64'(busy_o[k]), 64'(exp_busy(rs_i[k*AW +: AW])));
            end
            chk("busy_cnt", 64'(busy_cnt_o), 64'(exp_cnt()));
            chk("dbg_data", dbg_data_o, m_mem[int'(dbg_idx_i)]);
        end
    end

    task automatic idle();
        wen_i = '0; rd_i = '0; wdata_i = '0;
        alloc_i = 1'b0; alloc_rd_i = '0; flush_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset_n) model_step(); else model_clear();
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        rs_i = '0; dbg_idx_i = '0;
        idle();
        model_clear();
        #1 cmp_en = 1'b1;
        repeat (3) tick();
        reset_n = 1'b1;

        for (int i = 0; i < NREGS; i++) begin
            dbg_idx_i = AW'(i);
            tick();
            chk("reset_dbg", dbg_data_o, 64'd0);
        end
        chk("reset_cnt", 64'(busy_cnt_o), 64'd0);

        // x5 = 0xDEAD_BEEF through port 0
        rs_i = {5'd0, 5'd5};
        wen_i = 2'b01; rd_i = {5'd0, 5'd5}; wdata_i = {64'd0, 64'hDEAD_BEEF};
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("x5_same_cycle", rdata_o[63:0], 64'hDEAD_BEEF);
`else
        chk("x5_same_cycle", rdata_o[63:0], 64'd0);
`endif
        tick();
        idle();
        #1 chk("x5_next_cycle", rdata_o[63:0], 64'hDEAD_BEEF);

        // both ports hit x7, then a write to x0
        wen_i = 2'b11; rd_i = {5'd7, 5'd7}; wdata_i = {64'h22, 64'h11};
        tick();
        wen_i = 2'b01; rd_i = {5'd0, 5'd0}; wdata_i = {64'd0, 64'hFF};
        tick();
        idle();
        dbg_idx_i = 5'd7; rs_i = {5'd0, 5'd7};
        #1;
        chk("x7_port1_wins", dbg_data_o, 64'h22);
        chk("x0_rs", rdata_o[127:64], 64'd0);
        dbg_idx_i = 5'd0;
        #1 chk("x0_dbg", dbg_data_o, 64'd0);

        // scoreboard counting
        alloc_i = 1'b1; alloc_rd_i = 5'd3; tick();
        alloc_rd_i = 5'd4; tick();
        idle();
        #1 chk("cnt_two_allocs", 64'(busy_cnt_o), 64'd2);
        wen_i = 2'b01; rd_i = {5'd0, 5'd3}; wdata_i = {64'd0, 64'h33}; tick();
        idle();
        #1 chk("cnt_after_write", 64'(busy_cnt_o), 64'd1);
        alloc_i = 1'b1; alloc_rd_i = 5'd4; tick();
        idle();
        #1 chk("cnt_realloc", 64'(busy_cnt_o), 64'd1);

        // alloc and write to x9 together, then flush with alloc
        alloc_i = 1'b1; alloc_rd_i = 5'd9;
        wen_i = 2'b01; rd_i = {5'd0, 5'd9}; wdata_i = {64'd0, 64'h5};
        tick();
        idle();
        rs_i = {5'd0, 5'd9}; dbg_idx_i = 5'd9;
        #1;
        chk("x9_data", dbg_data_o, 64'h5);
        chk("x9_busy", 64'(busy_o[0]), 64'd1);
        chk("cnt_x4_x9", 64'(busy_cnt_o), 64'd2);
        flush_i = 1'b1; alloc_i = 1'b1; alloc_rd_i = 5'd10;
        tick();
        idle();
        #1 chk("cnt_after_flush", 64'(busy_cnt_o), 64'd0);

        // asynchronous reset between edges with x6 pending
        alloc_i = 1'b1; alloc_rd_i = 5'd6; tick();
        idle();
        rs_i = {5'd0, 5'd6}; dbg_idx_i = 5'd5;
        #1;
        chk("x6_busy", 64'(busy_o[0]), 64'd1);
        chk("x5_before_rst", dbg_data_o, 64'hDEAD_BEEF);
        #1 reset_n = 1'b0;
        model_clear();
        #1;
        chk("rst_async_busy", 64'(busy_o[0]), 64'd0);
        chk("rst_async_cnt", 64'(busy_cnt_o), 64'd0);
        chk("rst_async_data", dbg_data_o, 64'd0);
        #1 reset_n = 1'b1;
        repeat (2) tick();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
